// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants for the SimpleCPU datapath and controller:
//               data/register/immediate widths, ALU opcodes and the
//               register-file write-source encodings with their decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int DW   = 16;            // data / register width
  localparam int NREG = 16;            // number of registers
  localparam int AW   = $clog2(NREG);  // register address width
  localparam int CW   = 8;             // immediate constant width

  // ALU operation select (alu_s0)
  localparam logic ALU_ADD = 1'b1;
  localparam logic ALU_SUB = 1'b0;

  // Register-file write-source encodings, shared with the controller FSM
  localparam logic [1:0] WSRC_ALU     = 2'b00;
  localparam logic [1:0] WSRC_MEM     = 2'b01;
  localparam logic [1:0] WSRC_MEM_NOT = 2'b10;
  localparam logic [1:0] WSRC_CONST   = 2'b11;

  // Resolve the raw control bits into a write source. The constant wins over
  // the memory path, and the memory path wins over the ALU.
  function automatic logic [1:0] decode_wsrc(input logic cons,
                                             input logic s,
                                             input logic ext);
    logic [1:0] sel;
    sel = WSRC_ALU;
    if (cons == 1'b1) begin
      sel = WSRC_CONST;
    end else if (s == 1'b1) begin
      sel = (ext == 1'b1) ? WSRC_MEM_NOT : WSRC_MEM;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_datapath_register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : NREG x DW register file with two asynchronous read ports and
//               one synchronous write port; synchronous active-high reset
//               clears every register.
// Ports       : clk, rst            - clock, sync active-high reset
//               w_addr/w_en/w_data  - write port (written on posedge)
//               p_addr/p_en/p_data  - read port P (0 unless p_en == 1)
//               q_addr/q_en/q_data  - read port Q (0 unless q_en == 1)
// Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
  parameter int DW   = cpu_pkg::DW,
  parameter int NREG = cpu_pkg::NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] w_addr,
  input  logic          w_en,
  input  logic [DW-1:0] w_data,
  input  logic [AW-1:0] p_addr,
  input  logic          p_en,
  output logic [DW-1:0] p_data,
  input  logic [AW-1:0] q_addr,
  input  logic          q_en,
  output logic [DW-1:0] q_data
);

  logic [NREG-1:0][DW-1:0] regs_q;
  logic [NREG-1:0][DW-1:0] regs_d;

  // Next-state: only an enable of exactly 1 writes; 0 or X leaves state alone.
  always_comb begin
    regs_d = regs_q;
    if (w_en == 1'b1) begin
      regs_d[w_addr] = w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads come from the current flops, so a same-cycle write is not visible
  // until after the edge. A non-1 enable forces the port to zero.
  always_comb begin
    p_data = '0;
    if (p_en == 1'b1) begin
      p_data = regs_q[p_addr];
    end
  end

  always_comb begin
    q_data = '0;
    if (q_en == 1'b1) begin
      q_data = regs_q[q_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_datapath.sv
`default_nettype none
// ============================================================================
// Module      : cpu_datapath
// Description : SimpleCPU execute datapath: register file, add/sub ALU and
//               write-source mux. Single-cycle execute; result lands in the
//               register file on the rising edge that ends the cycle.
// Ports       : clk, rst                      - clock, sync active-high reset
//               RF_W_addr, RF_W_wr            - destination register / enable
//               RF_Rp_addr/rd, RF_Rq_addr/rd  - read ports P and Q
//               RF_s, RF_cons, RF_ext         - write-source select bits
//               alu_s0                        - 1 = add, 0 = subtract
//               Val_cons                      - immediate constant
//               R_data / W_data               - data memory read / write data
//               RF_Rp_zero                    - Rp_data == 0 flag
//               Rp_data, Rq_data              - read port observe outputs
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_datapath #(
  parameter int DW   = cpu_pkg::DW,
  parameter int NREG = cpu_pkg::NREG,
  parameter int CW   = cpu_pkg::CW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREG)-1:0]  RF_W_addr,
  input  logic                     RF_W_wr,
  input  logic [$clog2(NREG)-1:0]  RF_Rp_addr,
  input  logic                     RF_Rp_rd,
  input  logic [$clog2(NREG)-1:0]  RF_Rq_addr,
  input  logic                     RF_Rq_rd,
  input  logic                     RF_s,
  input  logic                     RF_cons,
  input  logic                     RF_ext,
  input  logic                     alu_s0,
  input  logic [CW-1:0]            Val_cons,
  input  logic [DW-1:0]            R_data,
  output logic [DW-1:0]            W_data,
  output logic                     RF_Rp_zero,
  output logic [DW-1:0]            Rp_data,
  output logic [DW-1:0]            Rq_data
);

  import cpu_pkg::*;

  logic [DW-1:0] alu_y;
  logic [DW-1:0] wsrc;
  logic [1:0]    wsrc_sel;

  register_file #(
    .DW   (DW),
    .NREG (NREG),
    .AW   ($clog2(NREG))
  ) u_register_file (
    .clk    (clk),
    .rst    (rst),
    .w_addr (RF_W_addr),
    .w_en   (RF_W_wr),
    .w_data (wsrc),
    .p_addr (RF_Rp_addr),
    .p_en   (RF_Rp_rd),
    .p_data (Rp_data),
    .q_addr (RF_Rq_addr),
    .q_en   (RF_Rq_rd),
    .q_data (Rq_data)
  );

  // Add/sub wraps modulo 2^DW; no carry is kept.
  always_comb begin
    alu_y = Rp_data - Rq_data;
    if (alu_s0 == ALU_ADD) begin
      alu_y = Rp_data + Rq_data;
    end
  end

  // Write-source mux. An undecodable select only matters when a write is
  // enabled, and the register file ignores wsrc otherwise.
  always_comb begin
    wsrc_sel = decode_wsrc(RF_cons, RF_s, RF_ext);
    wsrc     = alu_y;
    case (wsrc_sel)
      WSRC_CONST:   wsrc = {{(DW-CW){1'b0}}, Val_cons};
      WSRC_MEM_NOT: wsrc = ~R_data;
      WSRC_MEM:     wsrc = R_data;
      default:      wsrc = alu_y;
    endcase
  end

  assign W_data     = Rp_data;
  assign RF_Rp_zero = (Rp_data == '0);

endmodule
`default_nettype wire

// File: tb/tb_cpu_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_datapath
// Description : Directed self-checking bench for cpu_datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_datapath;

  logic        clk;
  logic        rst;
  logic [3:0]  RF_W_addr;
  logic        RF_W_wr;
  logic [3:0]  RF_Rp_addr;
  logic        RF_Rp_rd;
  logic [3:0]  RF_Rq_addr;
  logic        RF_Rq_rd;
  logic        RF_s;
  logic        RF_cons;
  logic        RF_ext;
  logic        alu_s0;
  logic [7:0]  Val_cons;
  logic [15:0] R_data;
  logic [15:0] W_data;
  logic        RF_Rp_zero;
  logic [15:0] Rp_data;
  logic [15:0] Rq_data;

  int n_vec  = 0;
  int n_miss = 0;

  cpu_datapath dut (
    .clk        (clk),
    .rst        (rst),
    .RF_W_addr  (RF_W_addr),
    .RF_W_wr    (RF_W_wr),
    .RF_Rp_addr (RF_Rp_addr),
    .RF_Rp_rd   (RF_Rp_rd),
    .RF_Rq_addr (RF_Rq_addr),
    .RF_Rq_rd   (RF_Rq_rd),
    .RF_s       (RF_s),
    .RF_cons    (RF_cons),
    .RF_ext     (RF_ext),
    .alu_s0     (alu_s0),
    .Val_cons   (Val_cons),
    .R_data     (R_data),
    .W_data     (W_data),
    .RF_Rp_zero (RF_Rp_zero),
    .Rp_data    (Rp_data),
    .Rq_data    (Rq_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled
  // 1 time unit after it, well clear of both edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RF_W_wr  = 1'b0;
    RF_Rp_rd = 1'b0;
    RF_Rq_rd = 1'b0;
    RF_s     = 1'b0;
    RF_cons  = 1'b0;
    RF_ext   = 1'b0;
    alu_s0   = 1'b0;
  endtask

  task automatic write_const(input logic [3:0] a, input logic [7:0] v);
    idle();
    RF_W_addr = a; RF_W_wr = 1'b1; RF_cons = 1'b1; Val_cons = v;
    tick();
    idle();
  endtask

  task automatic write_mem(input logic [3:0] a, input logic [15:0] v, input logic ext);
    idle();
    RF_W_addr = a; RF_W_wr = 1'b1; RF_s = 1'b1; RF_ext = ext; R_data = v;
    tick();
    idle();
  endtask

  task automatic read_pq(input logic [3:0] p, input logic [3:0] q);
    RF_Rp_addr = p; RF_Rp_rd = 1'b1;
    RF_Rq_addr = q; RF_Rq_rd = 1'b1;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      read_pq(4'(i), 4'(15 - i));
      chk({tag, "_rp"}, Rp_data, 16'h0000);
      chk({tag, "_rq"}, Rq_data, 16'h0000);
      chk({tag, "_zero"}, {15'd0, RF_Rp_zero}, 16'h0001);
    end
  endtask

  initial begin
    rst = 1'b1;
    RF_W_addr = '0; RF_Rp_addr = '0; RF_Rq_addr = '0;
    Val_cons = '0; R_data = '0;
    idle();
    tick();
    tick();
    // Outputs in reset with read enables off
    chk("rst_wdata", W_data, 16'h0000);
    chk("rst_zero", {15'd0, RF_Rp_zero}, 16'h0001);
    rst = 1'b0;
    check_all_zero("reset");

    // LOC: constant write, same-cycle read returns the old value
    idle();
    RF_W_addr = 4'd3; RF_W_wr = 1'b1; RF_cons = 1'b1; Val_cons = 8'hA5;
    read_pq(4'd3, 4'd3);
    chk("loc_rdw_old", Rp_data, 16'h0000);
    tick();
    RF_W_wr = 1'b0;
    #1;
    chk("loc_r3", Rp_data, 16'h00A5);
    chk("loc_r3_q", Rq_data, 16'h00A5);

    // ADD with wrap, then SUB with wrap
    write_mem(4'd1, 16'hFFFF, 1'b0);
    write_const(4'd2, 8'h02);
    RF_W_addr = 4'd4; RF_W_wr = 1'b1; alu_s0 = 1'b1;
    read_pq(4'd1, 4'd2);
    tick();
    idle();
    read_pq(4'd4, 4'd1);
    chk("add_r4", Rp_data, 16'h0001);
    chk("add_r1", Rq_data, 16'hFFFF);
    RF_W_addr = 4'd5; RF_W_wr = 1'b1; alu_s0 = 1'b0;
    read_pq(4'd2, 4'd1);
    tick();
    idle();
    read_pq(4'd5, 4'd2);
    chk("sub_r5", Rp_data, 16'h0003);

    // LOAD, LOAD-NOT, and constant overriding the memory path
    write_mem(4'd7, 16'h1234, 1'b0);
    write_mem(4'd8, 16'h1234, 1'b1);
    idle();
    RF_W_addr = 4'd9; RF_W_wr = 1'b1; RF_cons = 1'b1; RF_s = 1'b1; RF_ext = 1'b1;
    Val_cons = 8'h5A; R_data = 16'h1234;
    tick();
    idle();
    read_pq(4'd7, 4'd8);
    chk("load_r7", Rp_data, 16'h1234);
    chk("loadnot_r8", Rq_data, 16'hEDCB);
    read_pq(4'd9, 4'd9);
    chk("cons_wins_r9", Rp_data, 16'h005A);

    // JMZ / STORE view of r6
    read_pq(4'd6, 4'd6);
    chk("jmz_zero", {15'd0, RF_Rp_zero}, 16'h0001);
    chk("jmz_wdata0", W_data, 16'h0000);
    RF_W_addr = 4'd6; RF_W_wr = 1'b1; RF_cons = 1'b1; Val_cons = 8'h10;
    #1;
    chk("jmz_zero_same_cycle", {15'd0, RF_Rp_zero}, 16'h0001);
    tick();
    RF_W_wr = 1'b0; RF_cons = 1'b0;
    #1;
    chk("jmz_nonzero", {15'd0, RF_Rp_zero}, 16'h0000);
    chk("store_wdata", W_data, 16'h0010);

    // Disabled write with active selects must not touch state
    RF_W_addr = 4'd6; RF_W_wr = 1'b0; RF_cons = 1'b1; RF_s = 1'b1; Val_cons = 8'hEE;
    tick();
    idle();
    read_pq(4'd6, 4'd6);
    chk("nowr_r6", Rp_data, 16'h0010);

    // Disabled read port yields zero and forces the zero flag
    RF_Rp_rd = 1'b0;
    #1;
    chk("rd_off_rp", Rp_data, 16'h0000);
    chk("rd_off_zero", {15'd0, RF_Rp_zero}, 16'h0001);
    chk("rd_off_q_still", Rq_data, 16'h0010);

    // Register 0 is an ordinary register
    write_const(4'd0, 8'h77);
    read_pq(4'd0, 4'd3);
    chk("r0_write", Rp_data, 16'h0077);
    chk("r3_kept", Rq_data, 16'h00A5);

    // Reset coinciding with a write: write aborted, everything cleared
    idle();
    RF_W_addr = 4'd10; RF_W_wr = 1'b1; RF_cons = 1'b1; Val_cons = 8'hCC;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    read_pq(4'd10, 4'd10);
    chk("rstwr_r10", Rp_data, 16'h0000);
    check_all_zero("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
